shift_reg_n: RTL and testbench
==============================

Name: shift_reg_n

Overview:
- Parametrised W-bit universal shift register. It replaces the fixed 8-bit load/shift register built from two 4-bit slices.
- Adds selectable shift modes (logical right, left, arithmetic right, rotate right).
- Adds a multi-step shift engine: a Start/Count command runs N shifts autonomously, with Busy/Done handshake.
- Intended for shift-add multiplier and serial datapaths where the controller issues a shift count instead of pulsing Shift_En N times.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the Count input; derived, not overridden.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Load  input  1  parallel load of D (IDLE only).
- Shift_En  input  1  single shift step using live Op (IDLE only).
- Start  input  1  begin multi-step shift of Count steps (IDLE only).
- Op  input  2  00 logical right, 01 left, 10 arithmetic right, 11 rotate right.
- Count  input  CNT_W  number of shift steps for Start.
- Shift_In  input  1  serial fill bit for modes 00/01, sampled live each shift edge.
- D  input  WIDTH  parallel load data.
- A  output  WIDTH  register contents.
- Shift_Out  output  1  combinational: A[WIDTH-1] when the effective op is 01, else A[0].
- Busy  output  1  high while in SHIFT.
- Done  output  1  one-cycle pulse on completion of a Start command.

Behaviour:
- Reset (async, any time, including mid-SHIFT): A=0, state=IDLE, Busy=0, Done=0, internal count=0, latched op=00. Takes effect immediately, not at the next edge.
- Shift functions, one step:
  - 00: A <= {Shift_In, A[W-1:1]}.
  - 01: A <= {A[W-2:0], Shift_In}.
  - 10: A <= {A[W-1], A[W-1:1]}; Shift_In ignored.
  - 11: A <= {A[0], A[W-1:1]}; Shift_In ignored.
- Effective op: live Op in IDLE; the op latched at Start in SHIFT/DONE. Shift_Out follows the effective op.
- States: IDLE, SHIFT, DONE.
- IDLE, priority Load > Start > Shift_En; only the highest asserted acts on the edge:
  - Load: A<=D, stay IDLE.
  - Start with Count!=0: latch Op and Count, go to SHIFT; A unchanged on this edge.
  - Start with Count==0: go to DONE, A unchanged.
  - Shift_En: one step with live Op, stay IDLE.
  - None asserted: hold.
- SHIFT:
  - Each edge performs one step with the latched op and decrements the count.
  - The edge with count==1 performs the final step and goes to DONE.
  - Count=N gives exactly N shifts, on edges 1..N after the Start edge.
  - Count > WIDTH is honoured literally (e.g. rotate wraps; logical shifts fully flush).
- DONE: Done=1 for exactly one cycle; next edge returns to IDLE. A new Start is accepted from IDLE only, so back-to-back commands are spaced by at least one IDLE cycle.
- Busy=1 only in SHIFT. For Count=N: Busy high N cycles, Done high in cycle N+1 after Start, and Busy and Done never high together.
- In SHIFT and DONE, Load, Shift_En and Start are ignored; no queuing.
- Op and Count changes after Start have no effect on the running command.
- Outputs A, Busy and Done are registered; Shift_Out is combinational from A and the effective op.

Test Plan (WIDTH=8):
- Reset, Load D=8'hB5, then Shift_En Op=00 Shift_In=1 -> Shift_Out=1 before the edge; A=8'hDA after; Busy=0, Done=0 throughout.
- Load 8'h96, Start Op=10 Count=3 -> Busy=1 for 3 cycles; A goes 8'hCB, 8'hE5, 8'hF2; Done=1 for one cycle after, then IDLE with A=8'hF2.
- Load 8'hA5, Start Op=11 Count=8, toggle Op/Load/Shift_En during Busy -> A=8'hA5 at Done; toggles ignored; exactly 8 Busy cycles.
- Load 8'h81, Start Op=01 Count=1 Shift_In=0 -> Shift_Out=1 before the shift; A=8'h02; Done next cycle; Busy high 1 cycle.
- Start Count=0 with A=8'h3C -> Busy never 1; Done pulses the following cycle; A stays 8'h3C.
- Load=1, Start=1, Shift_En=1 in the same IDLE cycle with D=8'h11 -> A=8'h11, remains IDLE. Separately, assert Reset asynchronously mid-SHIFT -> A=0, Busy=0, Done=0 before the next Clk edge.

Source files
------------

// File: rtl/shift_reg_n.sv
// Parametrised universal shift register with single-step shifting and an
// autonomous multi-step shift engine (Start/Count with Busy/Done handshake).
module shift_reg_n #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Count,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] A,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       op_eff;

  // One shift step of the selected mode.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             sin);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SRL:  r = {sin, a[WIDTH-1:1]};
      OP_SLL:  r = {a[WIDTH-2:0], sin};
      OP_SRA:  r = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_ROR:  r = {a[0], a[WIDTH-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SRL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; Load > Start > Shift_En, and commands are accepted in IDLE only.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Load) begin
          a_d = D;
        end else if (Start) begin
          if (Count != '0) begin
            op_d    = Op;
            cnt_d   = Count;
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end else if (Shift_En) begin
          a_d = shift_step(Op, a_q, Shift_In);
        end
      end
      S_SHIFT: begin
        a_d   = shift_step(op_q, a_q, Shift_In);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // The serial output tracks whichever op the next shift would use.
  always_comb begin
    op_eff = (state_q == S_IDLE) ? Op : op_q;
  end

  assign Shift_Out = (op_eff == OP_SLL) ? a_q[WIDTH-1] : a_q[0];
  assign A         = a_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n at WIDTH=8: single steps, multi-step commands,
// command priority, ignored inputs while busy, and asynchronous reset.
module tb_shift_reg_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Load, Shift_En, Start, Shift_In;
  logic [1:0]       Op;
  logic [CNT_W-1:0] Count;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] A;
  logic             Shift_Out, Busy, Done;

  int tests = 0;
  int fails = 0;
  int busy_n;

  shift_reg_n #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Shift_En(Shift_En), .Start(Start),
    .Op(Op), .Count(Count), .Shift_In(Shift_In), .D(D),
    .A(A), .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Load = 1'b0; Shift_En = 1'b0; Start = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    D = val; Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  // Runs cycles until Done, counting Busy cycles; optionally scribbles on inputs meanwhile.
  task automatic wait_done(input bit scribble, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      check("busy_done_excl", 32'(Busy & Done), 32'd0);
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) nbusy++;
      if (scribble && Busy) begin
        Op = 2'(i); Load = i[0]; Shift_En = ~i[0]; Start = 1'b1; D = 8'hFF; Count = 4'd2;
      end
      tick();
    end
    idle_inputs();
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    Reset = 1'b1; idle_inputs();
    Op = 2'b00; Count = '0; Shift_In = 1'b0; D = '0;
    #12;
    check("rst_a", 32'(A), 32'h00);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    tick();

    // Single step, logical right with fill 1
    do_load(8'hB5);
    check("load_b5", 32'(A), 32'hB5);
    Op = 2'b00; Shift_In = 1'b1; Shift_En = 1'b1;
    #1;
    check("srl_sout_pre", 32'(Shift_Out), 32'd1);
    tick();
    Shift_En = 1'b0;
    check("srl_a", 32'(A), 32'hDA);
    check("srl_busy", 32'(Busy), 32'd0);
    check("srl_done", 32'(Done), 32'd0);

    // Arithmetic right by 3
    do_load(8'h96);
    Op = 2'b10; Count = 4'd3; Start = 1'b1;
    tick();
    Start = 1'b0; Op = 2'b00;
    check("sra_start_busy", 32'(Busy), 32'd1);
    check("sra_start_a", 32'(A), 32'h96);
    tick();
    check("sra_a1", 32'(A), 32'hCB);
    check("sra_busy1", 32'(Busy), 32'd1);
    tick();
    check("sra_a2", 32'(A), 32'hE5);
    check("sra_busy2", 32'(Busy), 32'd1);
    tick();
    check("sra_a3", 32'(A), 32'hF2);
    check("sra_done", 32'(Done), 32'd1);
    check("sra_busy3", 32'(Busy), 32'd0);
    tick();
    check("sra_idle_done", 32'(Done), 32'd0);
    check("sra_idle_a", 32'(A), 32'hF2);

    // Rotate right by 8 with inputs toggled while busy
    do_load(8'hA5);
    Op = 2'b11; Count = 4'd8; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(1'b1, busy_n);
    check("ror8_busy_n", 32'(busy_n), 32'd8);
    check("ror8_a", 32'(A), 32'hA5);
    tick();
    check("ror8_idle_done", 32'(Done), 32'd0);
    check("ror8_idle_a", 32'(A), 32'hA5);
    check("ror8_idle_busy", 32'(Busy), 32'd0);

    // Left by 1
    do_load(8'h81);
    Op = 2'b01; Count = 4'd1; Shift_In = 1'b0; Start = 1'b1;
    #1;
    check("sll_sout_pre", 32'(Shift_Out), 32'd1);
    tick();
    Start = 1'b0;
    check("sll_busy", 32'(Busy), 32'd1);
    check("sll_a_hold", 32'(A), 32'h81);
    tick();
    check("sll_a", 32'(A), 32'h02);
    check("sll_done", 32'(Done), 32'd1);
    check("sll_busy_off", 32'(Busy), 32'd0);
    tick();
    check("sll_done_off", 32'(Done), 32'd0);

    // Count of zero completes without shifting
    do_load(8'h3C);
    Op = 2'b00; Count = 4'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("c0_busy", 32'(Busy), 32'd0);
    check("c0_done", 32'(Done), 32'd1);
    check("c0_a", 32'(A), 32'h3C);
    tick();
    check("c0_done_off", 32'(Done), 32'd0);
    check("c0_a2", 32'(A), 32'h3C);

    // Count beyond width: rotate wraps, logical flushes
    do_load(8'hA5);
    Op = 2'b11; Count = 4'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(1'b0, busy_n);
    check("ror9_busy_n", 32'(busy_n), 32'd9);
    check("ror9_a", 32'(A), 32'hD2);
    tick();
    do_load(8'h81);
    Op = 2'b00; Count = 4'd10; Shift_In = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(1'b0, busy_n);
    check("srl10_busy_n", 32'(busy_n), 32'd10);
    check("srl10_a", 32'(A), 32'h00);
    tick();

    // Priority: Load wins over Start and Shift_En
    D = 8'h11; Count = 4'd3; Op = 2'b01; Shift_In = 1'b1;
    Load = 1'b1; Start = 1'b1; Shift_En = 1'b1;
    tick();
    idle_inputs();
    check("prio_a", 32'(A), 32'h11);
    check("prio_busy", 32'(Busy), 32'd0);
    tick();
    check("prio_busy2", 32'(Busy), 32'd0);
    check("prio_done2", 32'(Done), 32'd0);
    check("prio_a2", 32'(A), 32'h11);

    // Asynchronous reset mid-shift
    Op = 2'b11; Count = 4'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("mid_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("arst_a", 32'(A), 32'h00);
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_done", 32'(Done), 32'd0);
    #1 Reset = 1'b0;
    tick();
    check("arst_after_busy", 32'(Busy), 32'd0);
    check("arst_after_a", 32'(A), 32'h00);
    check("arst_after_done", 32'(Done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
